uart_rxd: RTL and testbench



---
 rtl/uart_rxd.sv | 123 ++++++++++++
 tb/tb_uart_rxd.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rxd.sv
// 8N1 UART receiver: synchronizes the serial line, times bits with an internal
// baud counter and samples each bit at its midpoint.
module uart_rxd #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rs232_rxd,
    output logic [7:0] o_data,
    output logic       o_rx_done,
    output logic       o_frame_err,
    output logic       o_rx_busy
);

    localparam int BIT_CNT_MAX = CLK_FREQ / BAUD_RATE;
    localparam int HALF_CNT    = BIT_CNT_MAX / 2;
    localparam int CNT_W       = $clog2(BIT_CNT_MAX);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_CNT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic             rxd_s1;
    logic             rxd_s2;
    logic             rxd_s3;
    logic [1:0]       state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;

    logic fall_edge;
    logic sample;
    logic wrap;

    assign fall_edge = rxd_s3 & ~rxd_s2;
    assign sample    = (baud_cnt == CNT_HALF);
    assign wrap      = (baud_cnt == CNT_LAST);
    assign o_rx_busy = (state != IDLE);

    // Synchronizers reset to the idle-high line level so reset release never fakes a start edge.
    // NOTE: non-blocking assignments make each stage capture the previous stage's old value,
    // forming a real shift chain; blocking would collapse it into one flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_s3 <= 1'b1;
        end else begin
            rxd_s1 <= i_rs232_rxd;
            rxd_s2 <= rxd_s1;
            rxd_s3 <= rxd_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            o_data      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;

            if (state == IDLE || wrap) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (fall_edge) begin
                        state   <= START;
                        bit_idx <= '0;
                    end
                end
                START: begin
                    // A start bit that is high again at mid-bit was only a glitch.
                    if (sample && rxd_s2) begin
                        state <= IDLE;
                    end else if (wrap) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (sample) begin
                        shift_reg[bit_idx] <= rxd_s2;
                    end
                    if (wrap) begin
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    // Leave at mid stop bit so a back-to-back start edge is never missed.
                    if (sample) begin
                        if (rxd_s2) begin
                            o_data    <= shift_reg;
                            o_rx_done <= 1'b1;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rxd.sv
// Self-checking bench for uart_rxd: a serial-line driver pushes the expected
// outcome of each frame into a scoreboard; a monitor pops and compares on every strobe.
module tb_uart_rxd;

    localparam int CPB = 434;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] o_data;
    logic       o_rx_done;
    logic       o_frame_err;
    logic       o_rx_busy;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         last_done_cyc = 0;
    logic [7:0] last_good = 8'h00;
    bit         prev_strobe = 1'b0;

    uart_rxd dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rs232_rxd(rxd),
        .o_data     (o_data),
        .o_rx_done  (o_rx_done),
        .o_frame_err(o_frame_err),
        .o_rx_busy  (o_rx_busy)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        rxd = v;
        repeat (n) @(negedge clk);
    endtask

    // Reference model: a frame with a high stop bit delivers its byte, a low stop bit is a framing error.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int cpb);
        exp_t e;
        e.is_err = !stop;
        e.data   = d;
        sb.push_back(e);
        drive_bit(1'b0, cpb);
        for (int i = 0; i < 8; i++) drive_bit(d[i], cpb);
        drive_bit(stop, cpb);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20000 && sb.size() != 0; i++) @(negedge clk);
        check("drain_timeout", sb.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, o_data, 8'h00);
        check({tag, "_done"}, o_rx_done, 1'b0);
        check({tag, "_ferr"}, o_frame_err, 1'b0);
        check({tag, "_busy"}, o_rx_busy, 1'b0);
    endtask

    task automatic partial_then_reset(input int cpb);
        logic [7:0] pat;
        pat = 8'hC3;
        drive_bit(1'b0, cpb);
        for (int i = 0; i < 4; i++) drive_bit(pat[i], cpb);
        drive_bit(pat[4], cpb / 2);
        check("midframe_busy", o_rx_busy, 1'b1);
        rst_n = 1'b0;
        rxd   = 1'b1;
        #1;
        check_reset_outputs("midframe_rst");
        last_good = 8'h00;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        drive_bit(1'b1, 100);
        send_frame(8'h7E, 1'b1, cpb);
        drive_bit(1'b1, 300);
        wait_drain();
        check("after_rst_data", o_data, 8'h7E);
    endtask

    // Monitor: every strobe must match the oldest scoreboard entry.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            prev_strobe = 1'b0;
        end else begin
            if (prev_strobe) check("pulse_width", {30'b0, o_rx_done, o_frame_err}, 0);
            if (o_rx_done || o_frame_err) begin
                check("exclusive", o_rx_done & o_frame_err, 1'b0);
                if (sb.size() == 0) begin
                    check("unexpected_strobe", {30'b0, o_rx_done, o_frame_err}, 0);
                end else begin
                    e = sb.pop_front();
                    check("strobe_kind", o_frame_err, e.is_err);
                    if (e.is_err) begin
                        check("data_hold", o_data, last_good);
                    end else begin
                        check("rx_data", o_data, e.data);
                        last_good = e.data;
                    end
                    last_done_cyc = cyc;
                end
            end
            prev_strobe = o_rx_done || o_frame_err;
        end
    end

    initial begin
        int         c;
        int         lat;
        logic [7:0] d;
        logic       stop;
        int         cpb;
        logic [7:0] loop_bytes[4];

        @(negedge clk);
        #1;
        check_reset_outputs("por");
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        drive_bit(1'b1, 50);

        // Single frame with latency measured from the pin edge (2 sync clocks + 4124 + register).
        c = cyc;
        send_frame(8'h55, 1'b1, CPB);
        drive_bit(1'b1, 200);
        wait_drain();
        lat = last_done_cyc - c;
        check_rng("latency", lat, 4126, 4128);
        check("single_data", o_data, 8'h55);
        check("single_busy", o_rx_busy, 1'b0);
        check("single_ferr", o_frame_err, 1'b0);

        // Reset in the middle of the run clears everything; idle line gives no strobes.
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_sim_rst");
        last_good = 8'h00;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        drive_bit(1'b1, 5000);
        check("idle_busy", o_rx_busy, 1'b0);

        // Frames every 5000 clocks, as a transmitter stage would send them.
        loop_bytes = '{8'hA5, 8'h00, 8'hFF, 8'h3C};
        for (int i = 0; i < 4; i++) begin
            send_frame(loop_bytes[i], 1'b1, CPB);
            drive_bit(1'b1, 5000 - 10 * CPB);
        end
        wait_drain();
        check("loop_last", o_data, 8'h3C);

        // Glitch of 100 clocks: busy rises, then drops at the start-bit sample point.
        c = cyc;
        drive_bit(1'b0, 100);
        check("glitch_busy", o_rx_busy, 1'b1);
        rxd = 1'b1;
        for (int i = 0; i < 1000 && o_rx_busy; i++) @(negedge clk);
        check_rng("glitch_release", cyc - c, 218, 224);
        drive_bit(1'b1, 500);

        // Framing error, long break, then recovery.
        send_frame(8'h81, 1'b0, CPB);
        drive_bit(1'b0, 20000);
        check("break_busy", o_rx_busy, 1'b0);
        drive_bit(1'b1, 100);
        wait_drain();
        check("break_hold", o_data, 8'h3C);
        send_frame(8'h12, 1'b1, CPB);
        drive_bit(1'b1, 300);
        wait_drain();
        check("recover_data", o_data, 8'h12);

        // Reset mid-frame at nominal rate and at +2% slower sender.
        partial_then_reset(CPB);
        partial_then_reset(443);

        // Random frames, random sender rate within +-2%, occasional framing errors, often back-to-back.
        for (int i = 0; i < 16; i++) begin
            d    = 8'($urandom);
            cpb  = $urandom_range(425, 443);
            stop = ($urandom_range(0, 5) != 0);
            send_frame(d, stop, cpb);
            if (!stop) drive_bit(1'b1, 50);
            else if ($urandom_range(0, 1) == 1) drive_bit(1'b1, $urandom_range(1, 300));
        end
        drive_bit(1'b1, 300);
        wait_drain();
        check("final_busy", o_rx_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
